// File: rtl/jump_controller.sv
// Jump sequencer for the player character: animates a one-column hop per video
// frame, then reports landing or a fall off the map to the game state machine.
module jump_controller #(
    parameter int N_COLS      = 8,
    parameter int START_COL   = 3,
    parameter int COL_W       = 64,
    parameter int X_OFFSET    = 32,
    parameter int Y_GROUND    = 400,
    parameter int Y_BOTTOM    = 600,
    parameter int JUMP_FRAMES = 16,
    parameter int DY          = 4,
    parameter int FALL_DY     = 8,
    localparam int COL_BITS   = $clog2(N_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                jump_left,
    input  logic                jump_right,
    input  logic                pos_reset,
    input  logic [N_COLS-1:0]   block_map,
    output logic [11:0]         char_x,
    output logic [11:0]         char_y,
    output logic [COL_BITS-1:0] char_col,
    output logic                busy,
    output logic                character_landed,
    output logic                jump_fail
);

    localparam int CNT_W = $clog2(JUMP_FRAMES + 1);
    localparam int DX    = COL_W / JUMP_FRAMES;
    localparam int HALF  = JUMP_FRAMES / 2;

    localparam logic [11:0]         DX_C       = 12'(DX);
    localparam logic [11:0]         DY_C       = 12'(DY);
    localparam logic [11:0]         COL_W_C    = 12'(COL_W);
    localparam logic [11:0]         X_OFF_C    = 12'(X_OFFSET);
    localparam logic [11:0]         Y_GROUND_C = 12'(Y_GROUND);
    localparam logic [11:0]         Y_BOTTOM_C = 12'(Y_BOTTOM);
    localparam logic [11:0]         START_X_C  = 12'(X_OFFSET + START_COL * COL_W);
    localparam logic [COL_BITS-1:0] START_C    = COL_BITS'(START_COL);
    localparam logic [COL_BITS-1:0] LAST_COL_C = COL_BITS'(N_COLS - 1);
    localparam logic [CNT_W-1:0]    HALF_END_C = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]    JUMP_END_C = CNT_W'(JUMP_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, RISE, DESCEND, CHECK, FALL, LOST} state_t;

    state_t              state_reg, state_next;
    logic                dir_reg, dir_next;          // 1 = moving right
    logic [COL_BITS-1:0] target_reg, target_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [11:0]         x_reg, x_next;
    logic [11:0]         y_reg, y_next;
    logic [COL_BITS-1:0] col_reg, col_next;
    logic                landed_reg, landed_next;
    logic                fail_reg, fail_next;

    logic [11:0] step_x;
    logic [11:0] land_x;
    logic [12:0] fall_sum;
    logic [11:0] fall_y;
    logic        left_ok;
    logic        right_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            dir_reg    <= 1'b0;
            target_reg <= START_C;
            cnt_reg    <= '0;
            x_reg      <= START_X_C;
            y_reg      <= Y_GROUND_C;
            col_reg    <= START_C;
            landed_reg <= 1'b0;
            fail_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dir_reg    <= dir_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            col_reg    <= col_next;
            landed_reg <= landed_next;
            fail_reg   <= fail_next;
        end
    end

    always_comb begin
        step_x   = dir_reg ? (x_reg + DX_C) : (x_reg - DX_C);
        land_x   = X_OFF_C + (12'(target_reg) * COL_W_C);
        fall_sum = {1'b0, y_reg} + 13'(FALL_DY);
        fall_y   = (fall_sum >= 13'(Y_BOTTOM)) ? Y_BOTTOM_C : fall_sum[11:0];
        left_ok  = (col_reg != '0);
        right_ok = (col_reg != LAST_COL_C);
    end

    always_comb begin
        state_next  = state_reg;
        dir_next    = dir_reg;
        target_next = target_reg;
        cnt_next    = cnt_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        col_next    = col_reg;
        landed_next = 1'b0;
        fail_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (jump_left ^ jump_right) begin
                    if ((jump_right && right_ok) || (jump_left && left_ok)) begin
                        state_next  = RISE;
                        dir_next    = jump_right;
                        target_next = jump_right ? (col_reg + 1'b1) : (col_reg - 1'b1);
                        cnt_next    = '0;
                    end else begin
                        // Blocked at the map edge: acknowledge without moving.
                        landed_next = 1'b1;
                    end
                end else if (jump_left && jump_right) begin
                    landed_next = 1'b1;
                end
            end
            RISE: begin
                if (frame_tick) begin
                    x_next   = step_x;
                    y_next   = y_reg - DY_C;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == HALF_END_C) begin
                        state_next = DESCEND;
                    end
                end
            end
            DESCEND: begin
                if (frame_tick) begin
                    x_next   = step_x;
                    y_next   = y_reg + DY_C;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == JUMP_END_C) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (block_map[target_reg]) begin
                    // Snap to the exact column origin on landing.
                    state_next  = IDLE;
                    col_next    = target_reg;
                    x_next      = land_x;
                    y_next      = Y_GROUND_C;
                    landed_next = 1'b1;
                end else begin
                    state_next = FALL;
                end
            end
            FALL: begin
                if (frame_tick) begin
                    y_next = fall_y;
                    if (fall_y == Y_BOTTOM_C) begin
                        state_next = LOST;
                        fail_next  = 1'b1;
                    end
                end
            end
            LOST: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (pos_reset) begin
            state_next  = IDLE;
            target_next = START_C;
            cnt_next    = '0;
            x_next      = START_X_C;
            y_next      = Y_GROUND_C;
            col_next    = START_C;
            landed_next = 1'b0;
            fail_next   = 1'b0;
        end
    end

    assign char_x           = x_reg;
    assign char_y           = y_reg;
    assign char_col         = col_reg;
    assign busy             = (state_reg != IDLE);
    assign character_landed = landed_reg;
    assign jump_fail        = fail_reg;

endmodule
